// File: rtl/demux4b_1to4_buf.sv
// 4-bit 1-to-4 demux: one nibble producer steered by sel into four per-channel
// FIFOs, each with its own valid/ready drain. Define DEMUX_TRISTATE_EN to float idle data outputs.

module demux4b_chan #(
   parameter int DEPTH = 2,
   parameter int CW    = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic [3:0]    din,
   input  logic          rdy,
   output logic [3:0]    dout,
   output logic          valid,
   output logic [CW-1:0] count
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [3:0]    mem [DEPTH];
   logic [PW-1:0] head, tail;
   logic [CW-1:0] cnt;
   logic [3:0]    last;
   logic          pop;

   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign valid = (cnt != '0);
   assign pop   = valid & rdy;
   assign count = cnt;

   always_ff @(posedge clk) begin
      if (push) mem[tail] <= din;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head <= '0;
         tail <= '0;
         cnt  <= '0;
         last <= '0;
      end else begin
         if (push) tail <= nxt(tail);
         if (pop)  head <= nxt(head);
         // remembers the head so an emptied channel keeps showing it
         if (valid) last <= mem[head];
         case ({push, pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

`ifdef DEMUX_TRISTATE_EN
   assign dout = valid ? mem[head] : 4'bzzzz;
`else
   assign dout = valid ? mem[head] : last;
`endif
endmodule

module demux4b_1to4_buf #(
   parameter int DEPTH = 2,
   parameter int CW    = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] in,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [1:0] sel,
   input  logic       enable,
   output logic [3:0] a,
   output logic [3:0] b,
   output logic [3:0] c,
   output logic [3:0] d,
   output logic       valid_a,
   output logic       valid_b,
   output logic       valid_c,
   output logic       valid_d,
   input  logic       ready_a,
   input  logic       ready_b,
   input  logic       ready_c,
   input  logic       ready_d,
   output logic       ovf
);
   logic [3:0][CW-1:0] cnt;
   logic [3:0][3:0]    dout;
   logic [3:0]         push, rdy, vld;

   assign rdy      = {ready_d, ready_c, ready_b, ready_a};
   assign in_ready = enable & (cnt[sel] != CW'(DEPTH));

   genvar i;
   generate
      for (i = 0; i < 4; i++) begin : g_ch
         assign push[i] = in_valid & in_ready & (sel == 2'(i));
         demux4b_chan #(.DEPTH(DEPTH), .CW(CW)) u_ch (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (push[i]),
            .din   (in),
            .rdy   (rdy[i]),
            .dout  (dout[i]),
            .valid (vld[i]),
            .count (cnt[i])
         );
      end
   endgenerate

   assign {d, c, b, a} = dout;
   assign {valid_d, valid_c, valid_b, valid_a} = vld;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         ovf <= 1'b0;
      else if (in_valid && enable && cnt[sel] == CW'(DEPTH))
         ovf <= 1'b1;
   end
endmodule

// File: tb/tb_demux4b_1to4_buf.sv
// Bench for demux4b_1to4_buf: directed scenarios plus random traffic checked
// against per-channel queue model.

module tb_demux4b_1to4_buf;
   localparam int DEPTH = 2;

   logic       clk = 0, rst_n = 0;
   logic [3:0] in = 0;
   logic       in_valid = 0, enable = 0;
   logic [1:0] sel = 0;
   logic [3:0] rdy = 0;
   logic       in_ready, ovf;
   logic [3:0] a, b, c, d;
   logic       valid_a, valid_b, valid_c, valid_d;

   int checks = 0, errors = 0;

   logic [3:0] q [4][$];
   logic [3:0] last [4];
   bit         ovf_m;

   wire [3:0][3:0] dv = {d, c, b, a};
   wire [3:0]      vv = {valid_d, valid_c, valid_b, valid_a};

   always #5 clk = ~clk;

   demux4b_1to4_buf #(.DEPTH(DEPTH), .CW(3)) dut (
      .clk(clk), .rst_n(rst_n), .in(in), .in_valid(in_valid), .in_ready(in_ready),
      .sel(sel), .enable(enable), .a(a), .b(b), .c(c), .d(d),
      .valid_a(valid_a), .valid_b(valid_b), .valid_c(valid_c), .valid_d(valid_d),
      .ready_a(rdy[0]), .ready_b(rdy[1]), .ready_c(rdy[2]), .ready_d(rdy[3]), .ovf(ovf)
   );

   function automatic logic [3:0] exp_data(int i);
`ifdef DEMUX_TRISTATE_EN
      if (q[i].size() == 0) return 4'bzzzz;
`endif
      return (q[i].size() != 0) ? q[i][0] : last[i];
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 4; i++) begin q[i].delete(); last[i] = 4'h0; end
      ovf_m = 0;
   endtask

   // one clock: decide pushes/pops from pre-edge state, then apply after the edge
   task automatic cycle();
      bit       pu;
      bit [3:0] po;
      pu = in_valid && enable && (q[sel].size() != DEPTH);
      if (in_valid && enable && q[sel].size() == DEPTH) ovf_m = 1;
      for (int i = 0; i < 4; i++) po[i] = rdy[i] && (q[i].size() != 0);
      @(posedge clk);
      for (int i = 0; i < 4; i++) if (po[i]) last[i] = q[i].pop_front();
      if (pu) q[sel].push_back(in);
      #1;
   endtask

   task automatic test_reset();
      #12;
      checks++; if (vv !== 4'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0000", vv); end
      checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
      for (int i = 0; i < 4; i++) begin
         checks++; if (dv[i] !== exp_data(i)) begin errors++; $display("FAIL reset_data ch%0d got=%h exp=%h", i, dv[i], exp_data(i)); end
      end
      enable = 1; #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      @(negedge clk) rst_n = 1;
      @(posedge clk); #1;
   endtask

   task automatic test_routing();
      logic [3:0] vals [4] = '{4'hA, 4'h5, 4'hC, 4'h3};
      for (int i = 0; i < 4; i++) begin
         in = vals[i]; sel = 2'(i); in_valid = 1; #1;
         checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL route_in_ready ch%0d got=%b exp=1", i, in_ready); end
         checks++; if (vv[i] !== 1'b0) begin errors++; $display("FAIL route_pre_valid ch%0d got=%b exp=0", i, vv[i]); end
         cycle();
         checks++; if (vv[i] !== 1'b1 || dv[i] !== vals[i]) begin errors++; $display("FAIL route_push ch%0d got=%b/%h exp=1/%h", i, vv[i], dv[i], vals[i]); end
      end
      in_valid = 0;
      for (int i = 0; i < 4; i++) begin
         checks++; if (dv[i] !== vals[i]) begin errors++; $display("FAIL route_hold ch%0d got=%h exp=%h", i, dv[i], vals[i]); end
      end
      rdy = 4'hF; cycle(); rdy = 0;
      checks++; if (vv !== 4'b0) begin errors++; $display("FAIL route_drain got=%b exp=0000", vv); end
      for (int i = 0; i < 4; i++) begin
         checks++; if (dv[i] !== exp_data(i)) begin errors++; $display("FAIL route_idle ch%0d got=%h exp=%h", i, dv[i], exp_data(i)); end
      end
   endtask

   task automatic test_fill_ovf();
      sel = 2; in_valid = 1;
      in = 4'h1; cycle();
      in = 4'h2; cycle();
      in = 4'h3; #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_in_ready got=%b exp=0", in_ready); end
      cycle(); in_valid = 0;
      checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL fill_ovf got=%b exp=1", ovf); end
      cycle();
      checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL fill_ovf_sticky got=%b exp=1", ovf); end
      checks++; if (c !== 4'h1) begin errors++; $display("FAIL fill_head got=%h exp=1", c); end
      rdy[2] = 1; cycle();
      checks++; if (c !== 4'h2 || valid_c !== 1'b1) begin errors++; $display("FAIL fill_pop1 got=%h/%b exp=2/1", c, valid_c); end
      cycle(); rdy[2] = 0;
      checks++; if (valid_c !== 1'b0 || c !== exp_data(2)) begin errors++; $display("FAIL fill_pop2 got=%h/%b exp=%h/0", c, valid_c, exp_data(2)); end
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fill_ready_back got=%b exp=1", in_ready); end
   endtask

   task automatic test_reset_mid();
      in = 4'h9; sel = 0; in_valid = 1; cycle(); in_valid = 0;
      #2 rst_n = 0; #1;
      model_clear();
      checks++; if (vv !== 4'b0 || ovf !== 1'b0) begin errors++; $display("FAIL rstmid_flags got=%b/%b exp=0000/0", vv, ovf); end
      for (int i = 0; i < 4; i++) begin
         checks++; if (dv[i] !== exp_data(i)) begin errors++; $display("FAIL rstmid_data ch%0d got=%h exp=%h", i, dv[i], exp_data(i)); end
      end
      @(negedge clk) rst_n = 1;
      @(posedge clk); #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready got=%b exp=1", in_ready); end
   endtask

   task automatic test_enable();
      in = 4'h6; sel = 0; in_valid = 1; cycle();
      enable = 0; in = 4'hF;
      for (int s = 0; s < 4; s++) begin
         sel = 2'(s); #1;
         checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL en_in_ready sel%0d got=%b exp=0", s, in_ready); end
         cycle();
         checks++; if (vv !== 4'b0001 || ovf !== 1'b0) begin errors++; $display("FAIL en_nopush got=%b/%b exp=0001/0", vv, ovf); end
      end
      in_valid = 0; rdy[0] = 1; cycle(); rdy = 0;
      checks++; if (valid_a !== 1'b0 || a !== exp_data(0)) begin errors++; $display("FAIL en_drain got=%b/%h exp=0/%h", valid_a, a, exp_data(0)); end
      enable = 1;
   endtask

   task automatic test_back_to_back();
      in = 4'h7; sel = 1; in_valid = 1; cycle();
      in = 4'h8; rdy[1] = 1; #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready got=%b exp=1", in_ready); end
      cycle(); in_valid = 0; rdy = 0;
      checks++; if (b !== 4'h8 || valid_b !== 1'b1) begin errors++; $display("FAIL b2b_data got=%h/%b exp=8/1", b, valid_b); end
      checks++; if (q[1].size() != 1) begin errors++; $display("FAIL b2b_model_count got=%0d exp=1", q[1].size()); end
      rdy[1] = 1; cycle(); rdy = 0;
      checks++; if (valid_b !== 1'b0) begin errors++; $display("FAIL b2b_drain got=%b exp=0", valid_b); end
   endtask

   task automatic test_wrap();
      sel = 3;
      for (int k = 0; k < 6; k++) begin
         in = 4'(k); in_valid = 1; rdy[3] = 0; cycle();
         in_valid = 0;
         checks++; if (d !== 4'(k) || valid_d !== 1'b1) begin errors++; $display("FAIL wrap_head k%0d got=%h/%b exp=%h/1", k, d, valid_d, 4'(k)); end
         rdy[3] = 1; cycle();
         checks++; if (valid_d !== 1'b0) begin errors++; $display("FAIL wrap_pop k%0d got=%b exp=0", k, valid_d); end
      end
      rdy = 0;
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         in = 4'($urandom); sel = 2'($urandom); in_valid = 1'($urandom);
         enable = ($urandom_range(0, 9) != 0); rdy = 4'($urandom);
         #1;
         checks++;
         if (in_ready !== (enable && q[sel].size() != DEPTH)) begin errors++; $display("FAIL rnd_in_ready n%0d got=%b", n, in_ready); end
         cycle();
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (vv[i] !== (q[i].size() != 0) || dv[i] !== exp_data(i)) begin
               errors++; $display("FAIL rnd_ch n%0d ch%0d got=%b/%h exp=%b/%h", n, i, vv[i], dv[i], q[i].size() != 0, exp_data(i));
            end
         end
         checks++; if (ovf !== ovf_m) begin errors++; $display("FAIL rnd_ovf n%0d got=%b exp=%b", n, ovf, ovf_m); end
      end
      in_valid = 0; rdy = 0; enable = 1;
   endtask

   initial begin
      model_clear();
      test_reset();
      test_routing();
      test_fill_ovf();
      test_reset_mid();
      test_enable();
      test_back_to_back();
      test_wrap();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
